// File: rtl/alu_pkg.sv
// Shared types for the ALU serial datapath.
// Holds the subtractor FSM encoding and the legal width limit.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    localparam int NBITS_MAX = 32;

endpackage

// File: rtl/subtractor_bit.sv
// One-bit full subtractor: d = a - b - br_in, with borrow-out.
module subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial A - B - B_IN, LSB first, with start/done handshake.
// Results and flags are registered and held until the next completion.
module subtractor_serial
    import alu_pkg::*;
#(
    parameter int Nbits = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [Nbits-1:0] A,
    input  logic [Nbits-1:0] B,
    input  logic             B_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [Nbits-1:0] DIFF,
    output logic             B_OUT,
    output logic             OVERFLOW,
    output logic             ZERO
);

    localparam int CW = $clog2(Nbits + 1);

    if (Nbits < 2 || Nbits > NBITS_MAX) begin : g_bad_width
        $error("subtractor_serial: Nbits out of range");
    end

    state_t           state_q, state_d;
    logic [Nbits-1:0] a_q, a_d;
    logic [Nbits-1:0] b_q, b_d;
    logic [Nbits-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [Nbits-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic bit_d;
    logic bit_br;
    logic accept;

    subtractor_bit u_bit (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .br_in  (br_q),
        .d      (bit_d),
        .br_out (bit_br)
    );

    // FIN counts as idle so back-to-back operations lose no cycle.
    assign accept = START && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_br;
                acc_d = {bit_d, acc_q[Nbits-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(Nbits - 1)) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                end
            end
            FIN: begin
                diff_d  = acc_q;
                bout_d  = br_q;
                ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ acc_q[Nbits-1]);
                zero_d  = ~|acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = A;
            b_d     = B;
            br_d    = B_IN;
            amsb_d  = A[Nbits-1];
            bmsb_d  = B[Nbits-1];
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign DIFF     = diff_q;
    assign B_OUT    = bout_q;
    assign OVERFLOW = ovf_q;
    assign ZERO     = zero_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboard bench for subtractor_serial (Nbits=4).
// Stimulus pushes expected results; a monitor pops them on DONE.
module tb_subtractor_serial;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         B_IN = 1'b0;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] DIFF;
    logic         B_OUT;
    logic         OVERFLOW;
    logic         ZERO;

    subtractor_serial #(.Nbits(N)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .A        (A),
        .B        (B),
        .B_IN     (B_IN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DIFF     (DIFF),
        .B_OUT    (B_OUT),
        .OVERFLOW (OVERFLOW),
        .ZERO     (ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int diff;
        int bout;
        int ovf;
        int zero;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int sa, sb_, sd, d;
        d = a - b - bin;
        e.diff = (d + 32) % 16;
        e.bout = (a < b + bin) ? 1 : 0;
        sa = (a >= 8) ? a - 16 : a;
        sb_ = (b >= 8) ? b - 16 : b;
        sd = sa - sb_ - bin;
        e.ovf = (sd < -8 || sd > 7) ? 1 : 0;
        e.zero = (e.diff == 0) ? 1 : 0;
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge CLK) begin
        if (RST_N && DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", int'(DIFF), e.diff);
                chk("b_out", int'(B_OUT), e.bout);
                chk("overflow", int'(OVERFLOW), e.ovf);
                chk("zero", int'(ZERO), e.zero);
                chk("latency", cyc - e.cyc, N + 1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) chk("busy_timeout", 1, 0);
    endtask

    task automatic push(input int a, input int b, input int bin);
        exp_t e;
        e = model(a, b, bin);
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Issue one operation; returns at the negedge of the first BUSY cycle.
    task automatic op(input int a, input int b, input int bin);
        @(negedge CLK);
        wait_idle();
        A = 4'(a);
        B = 4'(b);
        B_IN = 1'(bin);
        START = 1'b1;
        @(posedge CLK);
        #1;
        push(a, b, bin);
        @(negedge CLK);
        START = 1'b0;
        A = 4'($urandom_range(15));
        B = 4'($urandom_range(15));
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_diff", int'(DIFF), 0);
        chk("rst_bout", int'(B_OUT), 0);
        chk("rst_ovf", int'(OVERFLOW), 0);
        chk("rst_zero", int'(ZERO), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        op(5, 3, 0);
        op(3, 5, 0);
        op(5, 5, 0);
        op(8, 1, 0);
        op(7, 15, 0);
        op(5, 4, 1);
        op(0, 0, 1);

        // START on the 2nd BUSY cycle must be ignored.
        op(6, 2, 0);
        @(negedge CLK);
        chk("busy_2nd", int'(BUSY), 1);
        A = 4'd9;
        B = 4'd1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;

        // START held high: one accept per N+1 cycles.
        @(negedge CLK);
        wait_idle();
        START = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int a, b;
            a = $urandom_range(15);
            b = $urandom_range(15);
            A = 4'(a);
            B = 4'(b);
            B_IN = 1'b0;
            @(posedge CLK);
            #1;
            push(a, b, 0);
            @(negedge CLK);
            if (i == 3) START = 1'b0;
            A = 4'($urandom_range(15));
            B = 4'($urandom_range(15));
            wait_idle();
        end

        // Reset in the 3rd BUSY cycle aborts the operation.
        op(7, 2, 0);
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_done", int'(DONE), 0);
        chk("abort_diff", int'(DIFF), 0);
        chk("abort_bout", int'(B_OUT), 0);
        chk("abort_ovf", int'(OVERFLOW), 0);
        chk("abort_zero", int'(ZERO), 0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        op(9, 4, 1);

        for (int i = 0; i < 20; i++) begin
            op($urandom_range(15), $urandom_range(15), $urandom_range(1));
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("drain", sb.size(), 0);
        repeat (8) @(negedge CLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
